lfsr_count_decoder: RTL and testbench

Receiving end of the counter-to-LFSR converter. It takes an 8-bit LFSR reset value `dp` and recovers the count N that produced it. It does this by stepping a reference LFSR from the seed until the state matches, then presenting N on `n` with a `done` flag. It sits on the BIST/pattern-generator side, where the decoder closes the loop for count checking.

---
 rtl/lfsr_count_decoder.sv | 133 +++++++++++++
 tb/tb_lfsr_count_decoder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/lfsr_count_decoder.sv
// Recovers the count N that produced an 8-bit LFSR value by stepping a reference LFSR from SEED.
// Optional build macro LFSR_ZERO_CHECK_EN: reject the lock-up value 8'h00 immediately instead of searching.
module lfsr_count_decoder #(
    parameter logic [7:0] SEED = 8'h01,
    parameter logic [7:0] TAPS = 8'hB8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_dp,
    output logic [7:0] o_n,
    output logic       o_done,
    output logic       o_err,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DONE
    } state_t;

    state_t     r_state;
    logic       r_start_d;
    logic [7:0] r_ref;
    logic [7:0] r_cnt;
    logic [7:0] r_target;
    logic [7:0] r_n;
    logic       r_done;
    logic       r_err;
    logic       r_busy;

    state_t     w_state_nxt;
    logic       w_accept;
    logic [7:0] w_ref_nxt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_target_nxt;
    logic [7:0] w_n_nxt;
    logic       w_done_nxt;
    logic       w_err_nxt;
    logic       w_busy_nxt;

    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], ^(q & TAPS)};
    endfunction

    assign w_accept = i_start & ~r_start_d;

    always_comb begin
        w_state_nxt  = r_state;
        w_ref_nxt    = r_ref;
        w_cnt_nxt    = r_cnt;
        w_target_nxt = r_target;
        w_n_nxt      = r_n;
        w_done_nxt   = r_done;
        w_err_nxt    = r_err;
        w_busy_nxt   = r_busy;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_target_nxt = i_dp;
                    w_ref_nxt    = SEED;
                    w_cnt_nxt    = 8'd0;
                    w_done_nxt   = 1'b0;
                    w_err_nxt    = 1'b0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = ST_SEARCH;
`ifdef LFSR_ZERO_CHECK_EN
                    // The all-zero state can never be reached, so skip the 255-cycle search.
                    if (i_dp == 8'h00) begin
                        w_n_nxt     = 8'd0;
                        w_err_nxt   = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = ST_DONE;
                    end
`endif
                end
            end
            ST_SEARCH: begin
                if (r_ref == r_target) begin
                    w_n_nxt     = r_cnt;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == 8'd254) begin
                    w_n_nxt     = 8'd0;
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_ref_nxt = lfsr_step(r_ref);
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // start_d resets high so a start held through reset is not seen as an edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_start_d <= 1'b1;
            r_ref     <= SEED;
            r_cnt     <= 8'd0;
            r_target  <= 8'd0;
            r_n       <= 8'd0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_d <= i_start;
            r_ref     <= w_ref_nxt;
            r_cnt     <= w_cnt_nxt;
            r_target  <= w_target_nxt;
            r_n       <= w_n_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign o_n    = r_n;
    assign o_done = r_done;
    assign o_err  = r_err;
    assign o_busy = r_busy;

endmodule

// File: tb/tb_lfsr_count_decoder.sv
// Directed bench for lfsr_count_decoder; expected counts are hand-derived from the x^8+x^6+x^5+x^4+1 sequence.
module tb_lfsr_count_decoder;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] dp;
    logic [7:0] n;
    logic       done;
    logic       err;
    logic       busy;

    int checks;
    int errors;
    int busy_cnt;

    lfsr_count_decoder dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_start (start),
        .i_dp    (dp),
        .o_n     (n),
        .o_done  (done),
        .o_err   (err),
        .o_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Raise start with the given dp; returns just after the accepting edge E0 with start lowered.
    task automatic request(input logic [7:0] value);
        dp    = value;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        dp     = 8'h00;
        tick(3);
        chk("rst_n", n, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick(1);

        // N = 0
        request(8'h01);
        chk("n0_busy_e0", busy, 1);
        chk("n0_done_e0", done, 0);
        tick(1);
        chk("n0_n", n, 0);
        chk("n0_done", done, 1);
        chk("n0_err", err, 0);
        chk("n0_busy", busy, 0);

        // N = 4, dp changed after E0 must not matter
        request(8'h11);
        dp = 8'hFF;
        chk("n4_done_drop", done, 0);
        tick(4);
        chk("n4_done_early", done, 0);
        tick(1);
        chk("n4_n", n, 4);
        chk("n4_done", done, 1);

        // N = 5 restart from DONE
        request(8'h23);
        chk("n5_done_drop", done, 0);
        tick(5);
        chk("n5_done_early", done, 0);
        tick(1);
        chk("n5_n", n, 5);
        chk("n5_done", done, 1);
        chk("n5_err", err, 0);

        // N = 254 worst case, with a second start pulse mid-search that must be ignored
        request(8'h80);
        busy_cnt = busy ? 1 : 0;
        for (int i = 1; i <= 254; i++) begin
            if (i == 50) start = 1'b1;
            if (i == 52) start = 1'b0;
            tick(1);
            if (busy) busy_cnt++;
        end
        chk("n254_done_early", done, 0);
        tick(1);
        chk("n254_n", n, 254);
        chk("n254_done", done, 1);
        chk("n254_busy", busy, 0);
        chk("n254_busy_cycles", busy_cnt, 255);

        // dp = 0 is unreachable
        request(8'h00);
`ifdef LFSR_ZERO_CHECK_EN
        chk("z_err_e0", err, 1);
        chk("z_done_e0", done, 1);
        chk("z_n_e0", n, 0);
        chk("z_busy_e0", busy, 0);
        tick(3);
        chk("z_busy_later", busy, 0);
        chk("z_done_later", done, 1);
`else
        chk("z_busy_e0", busy, 1);
        chk("z_done_e0", done, 0);
        tick(254);
        chk("z_done_early", done, 0);
        tick(1);
        chk("z_err", err, 1);
        chk("z_done", done, 1);
        chk("z_n", n, 0);
        chk("z_busy", busy, 0);
`endif

        // Restart after an error clears err
        request(8'h02);
        chk("r_err_clr", err, 0);
        tick(2);
        chk("r_n", n, 1);
        chk("r_done", done, 1);

        // Reset in the middle of a search, start held high across release
        request(8'h80);
        tick(10);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        start = 1'b1;
        tick(1);
        chk("mid_rst_n", n, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_busy", busy, 0);
        tick(2);
        reset = 1'b0;
        tick(5);
        chk("held_busy", busy, 0);
        chk("held_done", done, 0);
        start = 1'b0;
        tick(1);
        request(8'h02);
        chk("post_busy", busy, 1);
        tick(1);
        chk("post_done_early", done, 0);
        tick(1);
        chk("post_n", n, 1);
        chk("post_done", done, 1);
        chk("post_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
